// File: rtl/decode_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and memory-wait freezes.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush/wait cycle counters.
module decode_hazard_ctrl #(
    parameter int unsigned LOAD_USE_STALL = 1,
    parameter int unsigned FLUSH_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_rn,
    input  logic [3:0]  id_rm,
    input  logic        id_uses_rn,
    input  logic        id_uses_rm,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic [3:0]  ex_rd,
    input  logic        br_taken,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_bubble,
    output logic        exmem_en,
    output logic [1:0]  state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_cycles,
    output logic [15:0] wait_cycles
`endif
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    localparam int unsigned     CNT_W      = 4;
    localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(LOAD_USE_STALL - 1);
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;
    state_t           eff_state;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             haz;

    assign haz = id_valid && ex_valid && ex_mem_read && (ex_rd != 4'hF) &&
                 ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

    // Leaving MEM_WAIT behaves exactly like the resumed state in the same cycle.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        cnt_d       = cnt_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_bubble = 1'b0;
        exmem_en    = 1'b0;
        eff_state   = (state_q == MEM_WAIT) ? ret_q : state_q;

        if (rst) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = RUN;
        end else if (mem_busy) begin
            state_d = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                ret_d = state_q;
            end
        end else begin
            case (eff_state)
                RUN: begin
                    if (br_taken) begin
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                        idex_en     = 1'b1;
                        exmem_en    = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        cnt_d       = FLUSH_INIT;
                        state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                    end else if (haz) begin
                        idex_en     = 1'b1;
                        idex_bubble = 1'b1;
                        exmem_en    = 1'b1;
                        cnt_d       = STALL_INIT;
                        state_d     = (LOAD_USE_STALL > 1) ? LOAD_STALL : RUN;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        state_d  = RUN;
                    end
                end
                LOAD_STALL: begin
                    idex_en     = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_en    = 1'b1;
                    cnt_d       = cnt_q - CNT_ONE;
                    state_d     = (cnt_q == CNT_ONE) ? RUN : LOAD_STALL;
                end
                FLUSH: begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    idex_en     = 1'b1;
                    exmem_en    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    cnt_d       = cnt_q - CNT_ONE;
                    state_d     = (cnt_q == CNT_ONE) ? RUN : FLUSH;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Configuration check: zero or over-range stall/flush lengths are not supported.
    always_ff @(posedge clk) begin
        assert (LOAD_USE_STALL >= 1 && LOAD_USE_STALL <= 15)
            else $error("decode_hazard_ctrl: LOAD_USE_STALL out of range 1..15");
        assert (FLUSH_CYCLES >= 1 && FLUSH_CYCLES <= 15)
            else $error("decode_hazard_ctrl: FLUSH_CYCLES out of range 1..15");
    end

`ifdef HAZARD_PERF_CNT_EN
    logic wait_hit;

    assign wait_hit = mem_busy && !pc_en && !ifid_en && !idex_en && !exmem_en;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
            wait_cycles  <= '0;
        end else begin
            if (idex_bubble && !ifid_flush && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (ifid_flush && (flush_cycles != 16'hFFFF)) begin
                flush_cycles <= flush_cycles + 16'd1;
            end
            if (wait_hit && (wait_cycles != 16'hFFFF)) begin
                wait_cycles <= wait_cycles + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Scoreboard bench for decode_hazard_ctrl: two parameterisations share one stimulus stream,
// a cycle-level reference model predicts every output.
module tb_decode_hazard_ctrl;

    localparam int unsigned LA = 1;
    localparam int unsigned FA = 2;
    localparam int unsigned LB = 3;
    localparam int unsigned FB = 3;

    typedef struct packed {
        logic       rst;
        logic       id_valid;
        logic [3:0] id_rn;
        logic [3:0] id_rm;
        logic       uses_rn;
        logic       uses_rm;
        logic       ex_valid;
        logic       ex_mem_read;
        logic [3:0] ex_rd;
        logic       br_taken;
        logic       mem_busy;
    } stim_t;

    // mode: 0 run, 1 load stall, 2 flush, 3 memory wait
    typedef struct {
        int mode;
        int remain;
        int ret;
        int sc;
        int fc;
        int wc;
    } model_t;

    typedef struct packed {
        logic [7:0]  outs;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [15:0] wc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_uses_rn, id_uses_rm, ex_valid, ex_mem_read, br_taken, mem_busy;
    logic [3:0] id_rn, id_rm, ex_rd;

    logic       pc_en_a, ifid_en_a, ifid_flush_a, idex_en_a, idex_bubble_a, exmem_en_a;
    logic       pc_en_b, ifid_en_b, ifid_flush_b, idex_en_b, idex_bubble_b, exmem_en_b;
    logic [1:0] state_a, state_b;
    exp_t       act_a, act_b;

    int errors = 0;
    int checks = 0;
    exp_t   q_a[$];
    exp_t   q_b[$];
    model_t m_a = '{0, 0, 0, 0, 0, 0};
    model_t m_b = '{0, 0, 0, 0, 0, 0};

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] sc_a, fc_a, wc_a, sc_b, fc_b, wc_b;
`endif

    decode_hazard_ctrl #(.LOAD_USE_STALL(LA), .FLUSH_CYCLES(FA)) u_dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_valid(ex_valid),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_en(pc_en_a), .ifid_en(ifid_en_a), .ifid_flush(ifid_flush_a), .idex_en(idex_en_a),
        .idex_bubble(idex_bubble_a), .exmem_en(exmem_en_a), .state(state_a)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc_a), .flush_cycles(fc_a), .wait_cycles(wc_a)
`endif
    );

    decode_hazard_ctrl #(.LOAD_USE_STALL(LB), .FLUSH_CYCLES(FB)) u_dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_valid(ex_valid),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_en(pc_en_b), .ifid_en(ifid_en_b), .ifid_flush(ifid_flush_b), .idex_en(idex_en_b),
        .idex_bubble(idex_bubble_b), .exmem_en(exmem_en_b), .state(state_b)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc_b), .flush_cycles(fc_b), .wait_cycles(wc_b)
`endif
    );

    always_comb begin
        act_a.outs = {pc_en_a, ifid_en_a, ifid_flush_a, idex_en_a, idex_bubble_a, exmem_en_a, state_a};
        act_b.outs = {pc_en_b, ifid_en_b, ifid_flush_b, idex_en_b, idex_bubble_b, exmem_en_b, state_b};
`ifdef HAZARD_PERF_CNT_EN
        act_a.sc = sc_a; act_a.fc = fc_a; act_a.wc = wc_a;
        act_b.sc = sc_b; act_b.fc = fc_b; act_b.wc = wc_b;
`else
        act_a.sc = '0; act_a.fc = '0; act_a.wc = '0;
        act_b.sc = '0; act_b.fc = '0; act_b.wc = '0;
`endif
    end

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Output bits {pc, ifid, flush, idex, bubble, exmem}; remain = cycles left after this one.
    function automatic exp_t step(input int L, input int F, inout model_t m, input stim_t s);
        exp_t       e;
        logic [5:0] o;
        logic       haz;
        int         eff;
        e.sc = 16'(m.sc);
        e.fc = 16'(m.fc);
        e.wc = 16'(m.wc);
        e.outs[1:0] = 2'(m.mode);
        haz = s.id_valid && s.ex_valid && s.ex_mem_read && (s.ex_rd != 4'hF) &&
              ((s.uses_rn && s.id_rn == s.ex_rd) || (s.uses_rm && s.id_rm == s.ex_rd));
        o = 6'b000000;
        if (s.rst) begin
            o = 6'b001010;
            m.mode = 0; m.remain = 0; m.ret = 0;
        end else if (s.mem_busy) begin
            if (m.mode != 3) m.ret = m.mode;
            m.mode = 3;
        end else begin
            eff = (m.mode == 3) ? m.ret : m.mode;
            if (eff == 0) begin
                if (s.br_taken) begin
                    o = 6'b111111;
                    m.remain = F - 1;
                    m.mode = (F > 1) ? 2 : 0;
                end else if (haz) begin
                    o = 6'b000111;
                    m.remain = L - 1;
                    m.mode = (L > 1) ? 1 : 0;
                end else begin
                    o = 6'b110101;
                    m.mode = 0;
                end
            end else begin
                o = (eff == 1) ? 6'b000111 : 6'b111111;
                m.remain = m.remain - 1;
                m.mode = (m.remain == 0) ? 0 : eff;
            end
        end
        e.outs[7:2] = o;
        if (s.rst) begin
            m.sc = 0; m.fc = 0; m.wc = 0;
        end else begin
            if (o[1] && !o[3]) m.sc = sat_inc(m.sc);
            if (o[3]) m.fc = sat_inc(m.fc);
            if (s.mem_busy && o == 6'b000000) m.wc = sat_inc(m.wc);
        end
        return e;
    endfunction

    task automatic check(input string nm, input exp_t e, input exp_t a);
        checks++;
        if (a.outs !== e.outs) begin
            errors++;
            $display("FAIL %s outs{pc,ifid,flush,idex,bubble,exmem,state} got %b expected %b at %0t",
                     nm, a.outs, e.outs, $time);
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (a.sc !== e.sc) begin
            errors++;
            $display("FAIL %s stall_cycles got %0d expected %0d at %0t", nm, a.sc, e.sc, $time);
        end
        checks++;
        if (a.fc !== e.fc) begin
            errors++;
            $display("FAIL %s flush_cycles got %0d expected %0d at %0t", nm, a.fc, e.fc, $time);
        end
        checks++;
        if (a.wc !== e.wc) begin
            errors++;
            $display("FAIL %s wait_cycles got %0d expected %0d at %0t", nm, a.wc, e.wc, $time);
        end
`endif
    endtask

    // Monitor: outputs are presented every cycle; sample mid-cycle.
    always @(negedge clk) begin
        if (q_a.size() != 0) check("dut_a", q_a.pop_front(), act_a);
        if (q_b.size() != 0) check("dut_b", q_b.pop_front(), act_b);
    end

    task automatic apply(input stim_t s);
        rst         = s.rst;
        id_valid    = s.id_valid;
        id_rn       = s.id_rn;
        id_rm       = s.id_rm;
        id_uses_rn  = s.uses_rn;
        id_uses_rm  = s.uses_rm;
        ex_valid    = s.ex_valid;
        ex_mem_read = s.ex_mem_read;
        ex_rd       = s.ex_rd;
        br_taken    = s.br_taken;
        mem_busy    = s.mem_busy;
        q_a.push_back(step(LA, FA, m_a, s));
        q_b.push_back(step(LB, FB, m_b, s));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pick_reg();
        return ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
    endfunction

    stim_t idle_s, rst_s, haz_s, hazf_s, br_s, busy_s, s;

    initial begin
        idle_s = '0;
        rst_s = '0;        rst_s.rst = 1'b1;
        haz_s = '0;
        haz_s.id_valid = 1'b1; haz_s.ex_valid = 1'b1; haz_s.ex_mem_read = 1'b1;
        haz_s.ex_rd = 4'd3; haz_s.id_rm = 4'd3; haz_s.uses_rm = 1'b1; haz_s.id_rn = 4'd7;
        hazf_s = haz_s;    hazf_s.ex_rd = 4'hF; hazf_s.id_rm = 4'hF;
        br_s = '0;         br_s.br_taken = 1'b1;
        busy_s = '0;       busy_s.mem_busy = 1'b1;

        rst = 1'b1; id_valid = 1'b0; id_rn = '0; id_rm = '0; id_uses_rn = 1'b0; id_uses_rm = 1'b0;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = '0; br_taken = 1'b0; mem_busy = 1'b0;
        @(posedge clk);
        #1;

        apply(rst_s); apply(rst_s);
        repeat (2) apply(idle_s);
        // load-use, then the r15 exclusion
        apply(haz_s); repeat (4) apply(idle_s);
        apply(hazf_s); repeat (2) apply(idle_s);
        // taken branch, branch+hazard priority, busy+branch priority
        apply(br_s); repeat (4) apply(idle_s);
        s = haz_s; s.br_taken = 1'b1;
        apply(s); repeat (4) apply(idle_s);
        s = br_s; s.mem_busy = 1'b1;
        apply(s); repeat (3) apply(idle_s);
        // memory wait starting in the second flush cycle
        apply(br_s); repeat (4) apply(busy_s); repeat (5) apply(idle_s);
        // memory wait inside a load stall, and reset abandoning a flush
        apply(haz_s); repeat (3) apply(busy_s); repeat (5) apply(idle_s);
        apply(br_s); apply(rst_s); repeat (3) apply(idle_s);
        // counter scenario: three hazards and one branch after a clean reset
        apply(rst_s);
        repeat (3) begin apply(haz_s); repeat (4) apply(idle_s); end
        apply(br_s); repeat (4) apply(idle_s);

        for (int i = 0; i < 2000; i++) begin
            s.rst         = ($urandom_range(0, 79) == 0);
            s.id_valid    = ($urandom_range(0, 3) != 0);
            s.id_rn       = pick_reg();
            s.id_rm       = pick_reg();
            s.uses_rn     = 1'($urandom_range(0, 1));
            s.uses_rm     = 1'($urandom_range(0, 1));
            s.ex_valid    = ($urandom_range(0, 3) != 0);
            s.ex_mem_read = 1'($urandom_range(0, 1));
            s.ex_rd       = pick_reg();
            s.br_taken    = ($urandom_range(0, 7) == 0);
            s.mem_busy    = ($urandom_range(0, 5) == 0);
            apply(s);
        end
        apply(idle_s);

        repeat (2) @(posedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain queues left a=%0d b=%0d expected 0", q_a.size(), q_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decode_hazard_ctrl.md
Name: decode_hazard_ctrl

Overview:
- Pipeline sequencing controller for the IF/ID and ID/EX (decode) latches and the EX/MEM latch.
- Detects load-use hazards between the instruction in decode and a load in EX.
- Squashes wrong-path instructions after a taken branch and freezes the pipe while data memory is busy.
- Drives per-latch enable, flush and bubble controls. Bubble means the ID/EX latch loads all-zero control signals.

Parameters:
- LOAD_USE_STALL, 1: bubble cycles inserted per load-use hazard. Legal range 1..15.
- FLUSH_CYCLES, 2: cycles of IF/ID flush plus ID/EX bubble after a taken branch. Legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode stage holds a valid instruction
- id_rn  in  4  first source register of the decode instruction
- id_rm  in  4  second source register of the decode instruction
- id_uses_rn  in  1  decode instruction reads id_rn
- id_uses_rm  in  1  decode instruction reads id_rm
- ex_valid  in  1  EX stage holds a valid (non-bubble) instruction
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  4  destination register of the EX instruction
- br_taken  in  1  branch in EX resolved taken (condition passed)
- mem_busy  in  1  data memory not ready; pipe must hold
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID latch enable
- ifid_flush  out  1  IF/ID latch loads a NOP
- idex_en  out  1  ID/EX latch enable
- idex_bubble  out  1  ID/EX latch loads zero control signals
- exmem_en  out  1  EX/MEM latch enable
- state  out  2  current FSM state, for debug

Behaviour:
- State and a 4-bit count register cnt are updated on posedge clk. Outputs are combinational from state, cnt and inputs (Mealy).
- States: RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3. A 2-bit ret_state register holds the state to resume after MEM_WAIT.
- rst=1 (sampled on clk): next state=RUN, cnt=0, ret_state=RUN.
- While rst=1, outputs are forced: pc_en=ifid_en=idex_en=exmem_en=0, ifid_flush=1, idex_bubble=1. rst mid-stall or mid-flush abandons it.
- Hazard definition: haz = id_valid & ex_valid & ex_mem_read & (ex_rd != 4'hF) & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd)).
- Event priority in RUN, highest first: mem_busy, then br_taken, then haz.
- RUN:
  - mem_busy: all enables 0, flush=bubble=0. ret_state=RUN, next MEM_WAIT.
  - br_taken: pc_en=ifid_en=idex_en=exmem_en=1, ifid_flush=1, idex_bubble=1. cnt=FLUSH_CYCLES-1. Next FLUSH if FLUSH_CYCLES>1, else RUN.
  - haz: pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1, exmem_en=1, ifid_flush=0. cnt=LOAD_USE_STALL-1. Next LOAD_STALL if LOAD_USE_STALL>1, else RUN.
  - otherwise: all enables 1, flush=bubble=0.
- LOAD_STALL:
  - Outputs same as the RUN haz case. cnt decrements; when cnt==1 at the edge, next RUN.
  - br_taken is ignored here because EX holds a bubble.
  - mem_busy: outputs freeze, ret_state=LOAD_STALL, cnt held, next MEM_WAIT.
- FLUSH:
  - All enables 1, ifid_flush=1, idex_bubble=1. cnt decrements; when cnt==1, next RUN.
  - br_taken is ignored.
  - mem_busy: freeze, ret_state=FLUSH, cnt held, next MEM_WAIT.
- MEM_WAIT:
  - While mem_busy=1: all enables 0, flush=bubble=0, cnt held.
  - In the cycle mem_busy=0: outputs and the next-state decision are exactly those ret_state would produce that cycle, with no lost cycle.
- Zero stall cycles are illegal. Parameter values outside 1..15 are a configuration error; a simulation assertion fires.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles, flush_cycles, wait_cycles (each out, 16 bits).
  - Each counts cycles where the respective condition holds: idex_bubble & !ifid_flush; ifid_flush; mem_busy with enables 0.
  - Counters saturate at 16'hFFFF and are cleared by rst.
- Undefined: the ports and the logic are absent. Core behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 with idle inputs -> outputs forced during reset; the next cycle state=0 and all enables=1.
- Load-use, LOAD_USE_STALL=1: ex_mem_read=1, ex_rd=3, ex_valid=1, id_rm=3, id_uses_rm=1 -> exactly 1 cycle with pc_en=0, ifid_en=0, idex_bubble=1, then RUN with enables=1. Repeat with ex_rd=4'hF -> no stall.
- Taken branch, FLUSH_CYCLES=2: br_taken=1 for 1 cycle -> ifid_flush=idex_bubble=1 for 2 cycles (state 0 then 2), then state 0.
- Priority: br_taken=1 and haz=1 together -> flush behaviour. mem_busy=1 plus br_taken=1 -> all enables 0, state 3.
- Memory wait inside a flush: FLUSH_CYCLES=3, mem_busy=1 for 4 cycles starting in the 2nd flush cycle -> enables 0 for 4 cycles, then 2 more flush cycles, then RUN.
- With HAZARD_PERF_CNT_EN: 3 load-use hazards and 1 branch (FLUSH_CYCLES=2) -> stall_cycles=3, flush_cycles=2. Preload near 16'hFFFF -> counters hold at 16'hFFFF.
